// File: rtl/array_stack_engine_if.sv
// array_stack_engine_if: command/response bus between a requester and the array stack engine.
interface array_stack_engine_if #(parameter int WIDTH = 12) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_array;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;
  logic [WIDTH-1:0] busy_count;
  modport master (
    output cmd_valid, cmd_op, cmd_array, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error, busy_count
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_array, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_error, busy_count
  );
endinterface

// File: rtl/array_stack_engine.sv
// array_stack_engine: allocates fixed-capacity stacks held in one shared single-port RAM
// and serves ALLOC/FREE/PUSH/POP/SIZE commands one at a time.
module array_stack_engine #(
  parameter int WIDTH   = 12,
  parameter int NARRAYS = 4,
  parameter int NAREA   = 8
) (
  input  logic clock,
  input  logic reset,
  array_stack_engine_if.slave bus
);
  localparam int AW = NARRAYS > 1 ? $clog2(NARRAYS) : 1;
  localparam int MW = NARRAYS * NAREA > 1 ? $clog2(NARRAYS * NAREA) : 1;
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, READ = 2'd2, RESP = 2'd3;
  localparam logic [2:0] OP_ALLOC = 3'd0, OP_FREE = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3, OP_SIZE = 3'd4;
  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] arr_q, arr_d, data_q, data_d;
  logic [WIDTH-1:0] size_q [NARRAYS];
  logic [WIDTH-1:0] size_d [NARRAYS];
  logic [NARRAYS-1:0] alloc_q, alloc_d;
  logic [WIDTH-1:0] stk_q [NARRAYS];
  logic [WIDTH-1:0] stk_d [NARRAYS];
  logic [WIDTH-1:0] sp_q, sp_d, allocs_q, allocs_d, busy_q, busy_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;
  logic [WIDTH-1:0] mem [NARRAYS*NAREA];
  logic [WIDTH-1:0] rd_q;
  logic             ram_we;
  logic [MW-1:0]    ram_addr;
  logic [AW-1:0]    idx, top, grant;
  logic [WIDTH-1:0] sz;
  logic             legal, al, err;

  assign idx   = arr_q[AW-1:0];
  assign legal = arr_q < WIDTH'(NARRAYS);
  assign al    = legal && alloc_q[idx];
  assign sz    = size_q[idx];
  assign top   = AW'(sp_q - 1'b1);
  assign grant = sp_q != '0 ? stk_q[top][AW-1:0] : allocs_q[AW-1:0];
  // All rejection rules are resolved here, before any state is touched.
  assign err = op_q == OP_ALLOC ? (sp_q == '0 && allocs_q >= WIDTH'(NARRAYS)) :
               op_q > OP_SIZE   ? 1'b1 :
               (!al || (op_q == OP_PUSH && sz == WIDTH'(NAREA)) || (op_q == OP_POP && sz == '0));
  assign ram_addr = MW'(32'(idx) * NAREA + 32'(op_q == OP_POP ? sz - 1'b1 : sz));
  assign ram_we   = state_q == EXEC && op_q == OP_PUSH && !err && !reset;

  assign bus.cmd_ready  = state_q == IDLE;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.busy_count = busy_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arr_d       = arr_q;
    data_d      = data_q;
    size_d      = size_q;
    alloc_d     = alloc_q;
    stk_d       = stk_q;
    sp_d        = sp_q;
    allocs_d    = allocs_q;
    busy_d      = busy_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    if (state_q == IDLE && bus.cmd_valid) begin
      state_d = EXEC;
      op_d    = bus.cmd_op;
      arr_d   = bus.cmd_array;
      data_d  = bus.cmd_data;
    end else if (state_q == EXEC) begin
      state_d     = (op_q == OP_POP && !err) ? READ : RESP;
      rsp_error_d = err;
      rsp_data_d  = '0;
      if (!err && op_q == OP_ALLOC) begin
        if (sp_q != '0) sp_d = sp_q - 1'b1;
        else allocs_d = allocs_q + 1'b1;
        alloc_d[grant] = 1'b1;
        size_d[grant]  = '0;
        rsp_data_d     = WIDTH'(grant);
      end
      if (!err && op_q == OP_FREE) begin
        alloc_d[idx]          = 1'b0;
        stk_d[sp_q[AW-1:0]]   = arr_q;
        sp_d                  = sp_q + 1'b1;
      end
      if (!err && op_q == OP_PUSH) size_d[idx] = sz + 1'b1;
      if (!err && op_q == OP_POP) size_d[idx] = sz - 1'b1;
      if (!err && op_q == OP_SIZE) rsp_data_d = sz;
      busy_d = allocs_d - sp_d;
    end else if (state_q == READ) begin
      rsp_data_d = rd_q;
      state_d    = RESP;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      arr_q       <= '0;
      data_q      <= '0;
      size_q      <= '{default: '0};
      alloc_q     <= '0;
      stk_q       <= '{default: '0};
      sp_q        <= '0;
      allocs_q    <= '0;
      busy_q      <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arr_q       <= arr_d;
      data_q      <= data_d;
      size_q      <= size_d;
      alloc_q     <= alloc_d;
      stk_q       <= stk_d;
      sp_q        <= sp_d;
      allocs_q    <= allocs_d;
      busy_q      <= busy_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Element RAM is deliberately not reset; stale words are unreachable once sizes clear.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= data_q;
    rd_q <= mem[ram_addr];
  end
endmodule

// File: tb/tb_array_stack_engine.sv
// tb_array_stack_engine: directed vectors with hand-computed responses for array_stack_engine.
module tb_array_stack_engine;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [11:0] rd;
  logic        er;
  int          lat;

  always #5 clock = ~clock;

  array_stack_engine_if #(.WIDTH(12)) bus ();
  array_stack_engine #(.WIDTH(12), .NARRAYS(4), .NAREA(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [11:0] arr, input logic [11:0] dat,
                     output logic [11:0] rdata, output logic rerr, output int l);
    @(posedge clock); #1;
    check("cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_array = arr;
    bus.cmd_data  = dat;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    l = 1;
    while (!bus.rsp_valid && l < 20) begin
      @(posedge clock); #1;
      l++;
    end
    check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    rdata = bus.rsp_data;
    rerr  = bus.rsp_error;
  endtask

  task automatic op_chk(input string tag, input logic [2:0] op, input logic [11:0] arr,
                        input logic [11:0] dat, input logic [11:0] exp_data,
                        input logic exp_err, input int exp_lat);
    run(op, arr, dat, rd, er, lat);
    check({tag, ".data"}, {20'd0, rd}, {20'd0, exp_data});
    check({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, ".lat"}, lat, exp_lat);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_array = 12'd0;
    bus.cmd_data  = 12'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst.valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst.err", {31'd0, bus.rsp_error}, 32'd0);
    check("rst.data", {20'd0, bus.rsp_data}, 32'd0);
    check("rst.busy", {20'd0, bus.busy_count}, 32'd0);
    reset = 1'b0;

    op_chk("alloc0", 3'd0, 12'd0, 12'd0, 12'd0, 1'b0, 2);
    check("busy1", {20'd0, bus.busy_count}, 32'd1);
    op_chk("push1", 3'd2, 12'd0, 12'd1, 12'd0, 1'b0, 2);
    op_chk("push2", 3'd2, 12'd0, 12'd2, 12'd0, 1'b0, 2);
    op_chk("pop2", 3'd3, 12'd0, 12'd0, 12'd2, 1'b0, 3);
    op_chk("pop1", 3'd3, 12'd0, 12'd0, 12'd1, 1'b0, 3);
    op_chk("size0", 3'd4, 12'd0, 12'd0, 12'd0, 1'b0, 2);

    op_chk("pop_empty", 3'd3, 12'd0, 12'd0, 12'd0, 1'b1, 2);
    op_chk("size_after", 3'd4, 12'd0, 12'd0, 12'd0, 1'b0, 2);

    for (int i = 0; i < 9; i++)
      op_chk($sformatf("fill%0d", i), 3'd2, 12'd0, 12'(10 + i), 12'd0, i == 8, 2);
    op_chk("size_full", 3'd4, 12'd0, 12'd0, 12'd8, 1'b0, 2);
    for (int i = 0; i < 8; i++)
      op_chk($sformatf("drain%0d", i), 3'd3, 12'd0, 12'd0, 12'(17 - i), 1'b0, 3);

    op_chk("push_unalloc", 3'd2, 12'd3, 12'd99, 12'd0, 1'b1, 2);
    op_chk("op6", 3'd6, 12'd0, 12'd0, 12'd0, 1'b1, 2);
    op_chk("size_range", 3'd4, 12'd5, 12'd0, 12'd0, 1'b1, 2);
    op_chk("free_unalloc", 3'd1, 12'd3, 12'd0, 12'd0, 1'b1, 2);
    op_chk("size_kept", 3'd4, 12'd0, 12'd0, 12'd0, 1'b0, 2);
    check("busy_kept", {20'd0, bus.busy_count}, 32'd1);

    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      op_chk($sformatf("alloc_n%0d", i), 3'd0, 12'd0, 12'd0, 12'(i), 1'b0, 2);
    check("busy4", {20'd0, bus.busy_count}, 32'd4);
    op_chk("alloc_exh", 3'd0, 12'd0, 12'd0, 12'd0, 1'b1, 2);
    op_chk("free2", 3'd1, 12'd2, 12'd0, 12'd0, 1'b0, 2);
    op_chk("free1", 3'd1, 12'd1, 12'd0, 12'd0, 1'b0, 2);
    check("busy2", {20'd0, bus.busy_count}, 32'd2);
    op_chk("free1_again", 3'd1, 12'd1, 12'd0, 12'd0, 1'b1, 2);
    op_chk("realloc1", 3'd0, 12'd0, 12'd0, 12'd1, 1'b0, 2);
    op_chk("realloc2", 3'd0, 12'd0, 12'd0, 12'd2, 1'b0, 2);
    check("busy4b", {20'd0, bus.busy_count}, 32'd4);

    op_chk("push7", 3'd2, 12'd0, 12'd7, 12'd0, 1'b0, 2);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_array = 12'd0;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clock); #1;
    check("abort.read_valid", {31'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort.valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort.ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("abort.busy", {20'd0, bus.busy_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check($sformatf("abort.quiet%0d", i), {31'd0, bus.rsp_valid}, 32'd0);
    end
    op_chk("alloc_after", 3'd0, 12'd0, 12'd0, 12'd0, 1'b0, 2);
    op_chk("size_after_rst", 3'd4, 12'd0, 12'd0, 12'd0, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
